transpose_interp: RTL and testbench
===================================

Name: transpose_interp

Overview:
- Multi-tap granular pitch shifter, the parametrised successor to the existing two-delay-line transposer. Sits in the per-channel audio path and runs at one sample per `sample_clk`.
- Input is written into one circular buffer. Two read taps, one WINDOW apart, sweep at a pitch-controlled rate with linear fractional interpolation.
- Taps are cross-faded with envelopes whose gains sum exactly to unity.
- Adds over the prior generation: reset, a warm-up mute, a pipelined datapath, a grain-boundary strobe and a latency-matched bypass.

Parameters:
- W, 16, sample and pitch width (signed).
- WINDOW, 512, grain length in samples; power of 2, ≥ 2*XFADE.
- XFADE, 64, cross-fade length in samples; power of 2, ≥ 2.
- FRAC_BITS, 12, fractional bits of the delay accumulator; pitch = 2^FRAC_BITS means 1 sample/cycle of delay drift.
- Derived: IB = log2(WINDOW); XB = log2(XFADE); DEPTH = 4*WINDOW; LAT = 4.

Ports:
- sample_clk  in  1  sole clock; one sample per rising edge.
- rst  in  1  synchronous, active-high reset.
- pitch  in  W  signed delay-drift rate per sample (two's complement, sign-extended into accumulator).
- bypass  in  1  1: output is dry input delayed LAT.
- sample_in  in  W  signed input sample.
- sample_out  out  W  signed output sample, registered.
- grain_wrap  out  1  one-cycle pulse when the accumulator integer part wraps.

Behaviour:
- Reset (rst=1 at an edge):
  - wp=0, acc=0, warm=0; all pipeline registers, sample_out and grain_wrap go to 0.
  - Buffer contents are not cleared.
  - Reset mid-operation restarts warm-up.
- Write side:
  - Every non-reset cycle, buf[wp] <= sample_in; wp <= wp+1 mod DEPTH.
- Accumulator:
  - acc is unsigned IB+FRAC_BITS bits; acc <= acc + sext(pitch), modular.
  - int = acc[top IB bits]; frac = acc[FRAC_BITS-1:0].
- grain_wrap:
  - Registered. Asserts the cycle after the add carries out (pitch>0) or borrows (pitch<0).
  - Never asserts for pitch=0.
- Taps (from registered acc, reading before this cycle's write):
  - Tap A: s0 = buf[wp-(int+1)], s1 = buf[wp-(int+2)].
  - Tap B: same, with WINDOW added to both delays.
  - All addresses mod DEPTH. Max delay 2*WINDOW+1 < DEPTH, so there is no read/write collision.
- Envelopes (computed from the same int, pipelined alongside the data):
  - int < XFADE: eA=int, eB=XFADE-int.
  - Otherwise: eA=XFADE, eB=0.
  - Width XB+1 unsigned; eA+eB == XFADE always.
- Pipeline (each stage registered):
  - Stage 1: register s0/s1 for both taps, eA/eB and frac.
  - Stage 2: y = s0 + (((s1-s0) * frac) >>> FRAC_BITS). Diff is W+1 bits; product W+1+FRAC_BITS. Arithmetic shift floors, so y lies between s0 and s1 and is truncated losslessly to W.
  - Stage 3: pA = yA*eA, pB = yB*eB, each signed W+XB+1.
  - Stage 4: sample_out = (pA+pB) >>> XB, truncated to W. Cannot overflow because eA+eB = XFADE.
- Latency:
  - With frac=0, a sample written at cycle t appears at sample_out at cycle t+D+LAT.
  - D is the tap delay selected at cycle t+D.
- Warm-up:
  - warm counts 0..2*WINDOW+2 and saturates.
  - While not saturated, the stage-4 result is forced to 0 (mute), delayed consistently through the pipeline.
- Bypass:
  - sample_out = sample_in delayed exactly LAT cycles through a dedicated shift chain.
  - Overrides mute. Accumulator, grain_wrap and buffer writes keep running.
  - Toggling bypass takes effect on the output LAT cycles later.
- Simultaneous rst and any other input: rst wins.

Test Plan (WINDOW=16, XFADE=4, FRAC_BITS=12, W=16):
1. rst high 3 cycles, then sample_in=1000, pitch=0, bypass=0 -> sample_out=0 and grain_wrap=0 for all cycles until warm-up ends (34 cycles + LAT); sample_out=1000 thereafter, grain_wrap never pulses.
2. pitch=0, silence after warm-up, single impulse sample_in=8000 at cycle t -> sample_out=8000 at exactly t+17+4 (tap B, eB=4); 0 at all other cycles.
3. pitch=4096 -> grain_wrap pulses every 16 cycles; pitch=-4096 -> same period, pulse follows the int 0->15 borrow; pitch=2048 -> period 32.
4. pitch=2048, input ramp sample_in[n]=16n after warm-up -> tap outputs interpolate at frac=0 and frac=0.5; sample_out is monotonic with steps that are multiples of 8, with no jump at grain_wrap (eA+eB=4 throughout).
5. bypass=1 during warm-up, random sample_in -> sample_out[n]=sample_in[n-4] bit-exact; deassert bypass -> wet path resumes 4 cycles later.
6. Mid-run (pitch=4096), rst for 1 cycle -> next cycle sample_out=0, grain_wrap=0, acc=0; warm-up mute repeats in full.

Source files
------------

// File: rtl/transpose_interp.sv
// Two-tap granular pitch shifter: circular buffer, sweeping interpolated taps one
// grain apart, unity-sum cross-fade envelopes, warm-up mute and a matched dry path.
module transpose_interp #(
    parameter int W         = 16,
    parameter int WINDOW    = 512,
    parameter int XFADE     = 64,
    parameter int FRAC_BITS = 12
) (
    input  logic         sample_clk,
    input  logic         rst,
    input  logic [W-1:0] pitch,
    input  logic         bypass,
    input  logic [W-1:0] sample_in,
    output logic [W-1:0] sample_out,
    output logic         grain_wrap
);

    localparam int IB       = $clog2(WINDOW);
    localparam int XB       = $clog2(XFADE);
    localparam int DEPTH    = 4 * WINDOW;
    localparam int AB       = $clog2(DEPTH);
    localparam int AW       = IB + FRAC_BITS;
    localparam int LAT      = 4;
    localparam int WARM_MAX = 2 * WINDOW + 2;
    localparam int WB       = $clog2(WARM_MAX + 1);
    localparam int EB       = XB + 1;
    localparam int PW       = W + FRAC_BITS + 2;
    localparam int MW       = W + XB + 1;
    localparam int SW       = MW + 1;

    logic [W-1:0]                mem_q [DEPTH];
    logic [AB-1:0]               wp_q;
    logic [AW-1:0]               acc_q;
    logic [WB-1:0]               warm_q;
    logic                        grain_wrap_q;

    logic signed [W-1:0]         s0a_q, s1a_q, s0b_q, s1b_q;
    logic [EB-1:0]               ea1_q, eb1_q;
    logic [FRAC_BITS-1:0]        frac1_q;
    logic                        mute1_q;

    logic signed [W-1:0]         ya2_q, yb2_q;
    logic [EB-1:0]               ea2_q, eb2_q;
    logic                        mute2_q;

    logic signed [MW-1:0]        pa3_q, pb3_q;
    logic                        mute3_q;

    logic [LAT-2:0]              byp_q;
    logic [LAT-2:0][W-1:0]       dry_q;
    logic [W-1:0]                sample_out_q;

    logic [AW:0]                 pitch_ext;
    logic [AW:0]                 acc_d;
    logic [IB-1:0]               tap_int;
    logic [FRAC_BITS-1:0]        tap_frac;
    logic [AB-1:0]               addr_a0, addr_a1, addr_b0, addr_b1;
    logic [EB-1:0]               env_a, env_b;
    logic signed [MW-1:0]        pa3_d, pb3_d;
    logic [W-1:0]                wet_d;

    // Floor-rounded linear interpolation; the result always lies between s0 and s1.
    function automatic logic signed [W-1:0] lerp(input logic signed [W-1:0] s0,
                                                 input logic signed [W-1:0] s1,
                                                 input logic [FRAC_BITS-1:0] f);
        logic signed [PW-1:0] diff;
        logic signed [PW-1:0] prod;
        diff = PW'(s1) - PW'(s0);
        prod = diff * $signed({{(W + 2){1'b0}}, f});
        return W'(PW'(s0) + (prod >>> FRAC_BITS));
    endfunction

    always_comb begin
        pitch_ext = {{(AW + 1 - W){pitch[W-1]}}, pitch};
        acc_d     = {1'b0, acc_q} + pitch_ext;
        tap_int   = acc_q[AW-1 -: IB];
        tap_frac  = acc_q[FRAC_BITS-1:0];
        addr_a0   = wp_q - AB'(tap_int) - AB'(1);
        addr_a1   = addr_a0 - AB'(1);
        addr_b0   = addr_a0 - AB'(WINDOW);
        addr_b1   = addr_a1 - AB'(WINDOW);
        if (tap_int < IB'(XFADE)) begin
            env_a = EB'(tap_int);
            env_b = EB'(XFADE) - EB'(tap_int);
        end else begin
            env_a = EB'(XFADE);
            env_b = '0;
        end
        pa3_d = MW'(ya2_q) * $signed({{W{1'b0}}, ea2_q});
        pb3_d = MW'(yb2_q) * $signed({{W{1'b0}}, eb2_q});
        wet_d = W'((SW'(pa3_q) + SW'(pb3_q)) >>> XB);
    end

    // Bit AW of the widened sum flags both a carry (pitch>0) and a borrow (pitch<0).
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            wp_q         <= '0;
            acc_q        <= '0;
            warm_q       <= '0;
            grain_wrap_q <= 1'b0;
            s0a_q        <= '0;
            s1a_q        <= '0;
            s0b_q        <= '0;
            s1b_q        <= '0;
            ea1_q        <= '0;
            eb1_q        <= '0;
            frac1_q      <= '0;
            mute1_q      <= 1'b0;
            ya2_q        <= '0;
            yb2_q        <= '0;
            ea2_q        <= '0;
            eb2_q        <= '0;
            mute2_q      <= 1'b0;
            pa3_q        <= '0;
            pb3_q        <= '0;
            mute3_q      <= 1'b0;
            byp_q        <= '0;
            dry_q        <= '0;
            sample_out_q <= '0;
        end else begin
            wp_q         <= wp_q + AB'(1);
            acc_q        <= acc_d[AW-1:0];
            grain_wrap_q <= acc_d[AW];
            if (warm_q != WB'(WARM_MAX)) begin
                warm_q <= warm_q + WB'(1);
            end

            s0a_q   <= $signed(mem_q[addr_a0]);
            s1a_q   <= $signed(mem_q[addr_a1]);
            s0b_q   <= $signed(mem_q[addr_b0]);
            s1b_q   <= $signed(mem_q[addr_b1]);
            ea1_q   <= env_a;
            eb1_q   <= env_b;
            frac1_q <= tap_frac;
            mute1_q <= (warm_q != WB'(WARM_MAX));

            ya2_q   <= lerp(s0a_q, s1a_q, frac1_q);
            yb2_q   <= lerp(s0b_q, s1b_q, frac1_q);
            ea2_q   <= ea1_q;
            eb2_q   <= eb1_q;
            mute2_q <= mute1_q;

            pa3_q   <= pa3_d;
            pb3_q   <= pb3_d;
            mute3_q <= mute2_q;

            byp_q <= {byp_q[LAT-3:0], bypass};
            dry_q <= {dry_q[LAT-3:0], sample_in};
            if (byp_q[LAT-2]) begin
                sample_out_q <= dry_q[LAT-2];
            end else if (mute3_q) begin
                sample_out_q <= '0;
            end else begin
                sample_out_q <= wet_d;
            end
        end
    end

    // Buffer is deliberately not cleared by reset; warm-up mute hides stale contents.
    always_ff @(posedge sample_clk) begin
        if (!rst) begin
            mem_q[wp_q] <= sample_in;
        end
    end

    assign sample_out = sample_out_q;
    assign grain_wrap = grain_wrap_q;

endmodule

// File: tb/tb_transpose_interp.sv
// Bench for transpose_interp: per-cycle comparison of sample_out and grain_wrap
// against a history-based reference model, directed phases then random traffic.
module tb_transpose_interp;

    localparam int W         = 16;
    localparam int WINDOW    = 16;
    localparam int XFADE     = 4;
    localparam int FRAC_BITS = 12;
    localparam int ACC_MOD   = WINDOW * (1 << FRAC_BITS);
    localparam int WARM      = 2 * WINDOW + 2;
    localparam int NMAX      = 4096;

    logic         sample_clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pitch = '0;
    logic         bypass = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic [W-1:0] sample_out;
    logic         grain_wrap;

    always #5 sample_clk = ~sample_clk;

    transpose_interp #(
        .W(W), .WINDOW(WINDOW), .XFADE(XFADE), .FRAC_BITS(FRAC_BITS)
    ) dut (
        .sample_clk(sample_clk),
        .rst(rst),
        .pitch(pitch),
        .bypass(bypass),
        .sample_in(sample_in),
        .sample_out(sample_out),
        .grain_wrap(grain_wrap)
    );

    // History of every driven cycle; acc_h/since_h are the delay position and
    // cycles-since-reset that hold during that cycle.
    int in_h    [NMAX];
    int pit_h   [NMAX];
    int acc_h   [NMAX];
    int since_h [NMAX];
    bit rst_h   [NMAX];
    bit byp_h   [NMAX];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    endtask

    function automatic int lerp_ref(input int s0, input int s1, input int f);
        longint p;
        p = longint'(s1 - s0) * longint'(f);
        return s0 + int'(p >>> FRAC_BITS);
    endfunction

    function automatic int exp_out(input int m);
        int r, d, f, ea, eb, ya, yb;
        for (int k = m - 4; k < m; k++) begin
            if (k < 0) return 0;
            if (rst_h[k]) return 0;
        end
        r = m - 4;
        if (byp_h[r]) return in_h[r];
        if (since_h[r] < WARM) return 0;
        d  = acc_h[r] / (1 << FRAC_BITS);
        f  = acc_h[r] % (1 << FRAC_BITS);
        ea = (d < XFADE) ? d : XFADE;
        eb = XFADE - ea;
        ya = lerp_ref(in_h[r - d - 1], in_h[r - d - 2], f);
        yb = lerp_ref(in_h[r - d - 1 - WINDOW], in_h[r - d - 2 - WINDOW], f);
        return (ya * ea + yb * eb) >>> $clog2(XFADE);
    endfunction

    function automatic int exp_gw(input int m);
        int a;
        if (m < 1) return 0;
        if (rst_h[m-1]) return 0;
        a = acc_h[m-1] + pit_h[m-1];
        return (a >= ACC_MOD || a < 0) ? 1 : 0;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    task automatic step(input bit r, input int p, input bit b, input int s);
        int n;
        n = cyc;
        if (n >= NMAX - 1) begin
            $display("FAIL budget cyc=%0d got=%0d exp=%0d", cyc, n, NMAX - 1);
            $fatal(1, "history overflow");
        end
        if (n == 0) begin
            acc_h[0]   = 0;
            since_h[0] = 0;
        end else if (rst_h[n-1]) begin
            acc_h[n]   = 0;
            since_h[n] = 0;
        end else begin
            acc_h[n]   = (acc_h[n-1] + pit_h[n-1] + ACC_MOD) % ACC_MOD;
            since_h[n] = since_h[n-1] + 1;
        end
        rst_h[n] = r;
        pit_h[n] = p;
        byp_h[n] = b;
        in_h[n]  = s;
        rst       = r;
        pitch     = 16'(p);
        bypass    = b;
        sample_in = 16'(s);
        @(posedge sample_clk);
        #1;
        cyc++;
        chk("out", int'($signed(sample_out)), exp_out(cyc));
        chk("gw", int'(grain_wrap), exp_gw(cyc));
    endtask

    initial begin
        int p;
        bit b;
        // warm-up mute with constant input, pitch 0
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0, 1000);
        for (int i = 0; i < 60; i++) step(1'b0, 0, 1'b0, 1000);
        // single impulse through tap B at delay WINDOW+1
        for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b0, 0);
        step(1'b0, 0, 1'b0, 8000);
        for (int i = 0; i < 30; i++) step(1'b0, 0, 1'b0, 0);
        // grain_wrap periods for +1, -1 and +0.5 samples/cycle
        for (int i = 0; i < 80; i++) step(1'b0, 4096, 1'b0, rnd16());
        for (int i = 0; i < 80; i++) step(1'b0, -4096, 1'b0, rnd16());
        for (int i = 0; i < 80; i++) step(1'b0, 2048, 1'b0, rnd16());
        // ramp with half-sample drift exercises frac=0.5 interpolation
        for (int i = 0; i < 100; i++) step(1'b0, 2048, 1'b0, 16 * i);
        // bypass during warm-up, then back to the wet path
        step(1'b1, 0, 1'b0, 0);
        for (int i = 0; i < 40; i++) step(1'b0, 4096, 1'b1, rnd16());
        for (int i = 0; i < 60; i++) step(1'b0, 4096, 1'b0, rnd16());
        // reset in the middle of a sweep
        for (int i = 0; i < 30; i++) step(1'b0, 4096, 1'b0, rnd16());
        step(1'b1, 4096, 1'b1, rnd16());
        for (int i = 0; i < 60; i++) step(1'b0, 4096, 1'b0, rnd16());
        // random traffic
        p = 0;
        b = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 37 == 0) begin
                case ($urandom_range(0, 3))
                    0: p = rnd16();
                    1: p = int'($urandom_range(0, 16384)) - 8192;
                    2: p = 0;
                    default: p = ($urandom_range(0, 1) == 0) ? 4096 : -4096;
                endcase
            end
            if (i % 50 == 0) b = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 399) == 0, p, b, rnd16());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
